// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus arbiter: FSM states, requester indices, owner width.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int N_REQ_DEF = 3;
  localparam int OWNER_W   = 2;

  localparam int REQ_FETCH = 0;
  localparam int REQ_EU    = 1;
  localparam int REQ_IO    = 2;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin winner select: search starts one past last_owner and wraps; pure combinational.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic [OWNER_W-1:0] winner,
  output logic               valid
);

  logic [OWNER_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = OWNER_W'((int'(last_owner) + i) % N_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arb.sv
// Round-robin BIU bus arbiter with lock bursts, watchdog revoke and a one-cycle turnaround.
// Grant appears one cycle after req is sampled; xfer_done/timeout appear the cycle after the deciding edge.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_BURST   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     lock,
  input  logic [2*N_REQ-1:0]   sel_in,
  input  logic [2*N_REQ-1:0]   op_in,
  input  logic                 ready_biu,
  output logic [N_REQ-1:0]     gnt,
  output logic [OWNER_W-1:0]   owner,
  output logic                 cs_biu,
  output logic [1:0]           sel,
  output logic [1:0]           op_sel,
  output logic                 xfer_done,
  output logic                 timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  state_t               state, state_nxt;
  logic [N_REQ-1:0]     gnt_nxt;
  logic [OWNER_W-1:0]   owner_nxt, last_owner, last_owner_nxt;
  logic                 cs_nxt, done_nxt, tmo_nxt, rel;
  logic [1:0]           sel_nxt, op_nxt;
  logic [WD_W-1:0]      wd, wd_nxt;
  logic [BC_W-1:0]      burst, burst_nxt;
  logic [OWNER_W-1:0]   win;
  logic                 win_vld;

  logic                 own_req, own_lock;
  logic [1:0]           own_sel, own_op;

  assign own_req  = req[owner];
  assign own_lock = lock[owner];
  assign own_sel  = sel_in[{owner, 1'b0} +: 2];
  assign own_op   = op_in[{owner, 1'b0} +: 2];

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (win),
    .valid      (win_vld)
  );

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cs_nxt         = cs_biu;
    sel_nxt        = sel;
    op_nxt         = op_sel;
    done_nxt       = 1'b0;
    tmo_nxt        = 1'b0;
    wd_nxt         = wd;
    burst_nxt      = burst;
    rel            = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        cs_nxt  = 1'b0;
        sel_nxt = 2'b00;
        op_nxt  = 2'b00;
        if (win_vld) begin
          state_nxt      = XFER;
          gnt_nxt[win]   = 1'b1;
          owner_nxt      = win;
          last_owner_nxt = win;
          cs_nxt         = 1'b1;
          sel_nxt        = sel_in[{win, 1'b0} +: 2];
          op_nxt         = op_in[{win, 1'b0} +: 2];
          wd_nxt         = '0;
          burst_nxt      = '0;
        end
      end
      XFER: begin
        // A completing transfer beats both abort and watchdog expiry in the same cycle.
        if (ready_biu) begin
          done_nxt = 1'b1;
          wd_nxt   = '0;
          if (own_lock && own_req && (int'(burst) < MAX_BURST - 1)) begin
            burst_nxt = burst + 1'b1;
            sel_nxt   = own_sel;
            op_nxt    = own_op;
          end else begin
            rel = 1'b1;
          end
        end else if (!own_req) begin
          rel = 1'b1;
        end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
          tmo_nxt = 1'b1;
          rel     = 1'b1;
        end else begin
          wd_nxt  = wd + 1'b1;
          sel_nxt = own_sel;
          op_nxt  = own_op;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cs_nxt    = 1'b0;
        sel_nxt   = 2'b00;
        op_nxt    = 2'b00;
      end
      default: state_nxt = IDLE;
    endcase
    if (rel) begin
      state_nxt = RELEASE;
      gnt_nxt   = '0;
      cs_nxt    = 1'b0;
      sel_nxt   = 2'b00;
      op_nxt    = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= OWNER_W'(N_REQ - 1);
      cs_biu     <= 1'b0;
      sel        <= 2'b00;
      op_sel     <= 2'b00;
      xfer_done  <= 1'b0;
      timeout    <= 1'b0;
      wd         <= '0;
      burst      <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cs_biu     <= cs_nxt;
      sel        <= sel_nxt;
      op_sel     <= op_nxt;
      xfer_done  <= done_nxt;
      timeout    <= tmo_nxt;
      wd         <= wd_nxt;
      burst      <= burst_nxt;
    end
  end

endmodule
